// File: rtl/mod_counter_if.sv
// Control/status bundle for mod_counter. Defining COUNTER_MATCH_EN adds the
// match_val/match compare pair.
interface mod_counter_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
);
    logic              start;
    logic              stop;
    logic              enable;
    logic              up_down;
    logic [1:0]        mode;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  limit;
    logic              load_en;
    logic [WIDTH-1:0]  load_val;
    logic [WIDTH-1:0]  count;
    logic              busy;
    logic              done;
    logic              tc;
`ifdef COUNTER_MATCH_EN
    logic [WIDTH-1:0]  match_val;
    logic              match;

    modport master (
        output start, stop, enable, up_down, mode, step, limit, load_en, load_val, match_val,
        input  count, busy, done, tc, match
    );
    modport slave (
        input  start, stop, enable, up_down, mode, step, limit, load_en, load_val, match_val,
        output count, busy, done, tc, match
    );
`else
    modport master (
        output start, stop, enable, up_down, mode, step, limit, load_en, load_val,
        input  count, busy, done, tc
    );
    modport slave (
        input  start, stop, enable, up_down, mode, step, limit, load_en, load_val,
        output count, busy, done, tc
    );
`endif
endinterface

// File: rtl/mod_counter.sv
// Up/down modulus counter with wrap/saturate/one-shot modes and a run/stop FSM.
// Optional COUNTER_MATCH_EN adds a registered count == match_val flag.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   S_IDLE | stopped, count frozen; start -> S_RUN
//   S_RUN  | counting while enable is high
//   S_DONE | one-shot reached its bound, count frozen; start -> S_RUN
module mod_counter #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic          clk,
    input  logic          reset,
    mod_counter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             busy_q, done_q;

    logic [WIDTH:0]   cnt_x, lim_x, stp_x, bound_x;
    logic [WIDTH:0]   raw_up, raw_dn, up_wrap, dn_wrap;
    logic             over_up, under_dn;
    logic             is_sat, is_os;
    logic [WIDTH-1:0] load_clamped;

    // Everything is evaluated one bit wider so overflow and borrow are visible.
    assign cnt_x    = {1'b0, count_q};
    assign lim_x    = {1'b0, bus.limit};
    assign stp_x    = (WIDTH+1)'(bus.step);
    assign bound_x  = lim_x + 1'b1;
    assign raw_up   = cnt_x + stp_x;
    assign raw_dn   = cnt_x - stp_x;
    assign up_wrap  = raw_up - bound_x;
    assign dn_wrap  = cnt_x + bound_x - stp_x;
    assign over_up  = raw_up > lim_x;
    assign under_dn = stp_x > cnt_x;

    assign is_sat = (bus.mode == 2'd1);
    assign is_os  = (bus.mode == 2'd2);

    assign load_clamped = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
        if (bus.stop) begin
            state_d = S_IDLE;
        end else if (bus.load_en) begin
            count_d = load_clamped;
            if (bus.start) state_d = S_RUN;
        end else if (bus.start) begin
            state_d = S_RUN;
        end else if (state_q == S_RUN && bus.enable && bus.step != '0) begin
            if (bus.up_down) begin
                if (over_up) begin
                    tc_d = 1'b1;
                    if (is_sat) begin
                        count_d = bus.limit;
                    end else if (is_os) begin
                        count_d = bus.limit;
                        state_d = S_DONE;
                    end else begin
                        count_d = up_wrap[WIDTH-1:0];
                    end
                end else begin
                    count_d = raw_up[WIDTH-1:0];
                    if (is_os && raw_up == lim_x) begin
                        tc_d    = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end else begin
                if (under_dn) begin
                    tc_d = 1'b1;
                    if (is_sat) begin
                        count_d = '0;
                    end else if (is_os) begin
                        count_d = '0;
                        state_d = S_DONE;
                    end else begin
                        count_d = dn_wrap[WIDTH-1:0];
                    end
                end else begin
                    count_d = raw_dn[WIDTH-1:0];
                    if (is_os && raw_dn == '0) begin
                        tc_d    = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            busy_q  <= (state_d == S_RUN);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign bus.count = count_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.tc    = tc_q;

`ifdef COUNTER_MATCH_EN
    logic match_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) match_q <= 1'b0;
        else       match_q <= (count_d == bus.match_val);
    end

    assign bus.match = match_q;
`endif

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: directed scenarios then random stimulus,
// expected outputs from an arithmetic reference model queued per clock.
module tb_mod_counter;

    localparam int WIDTH  = 8;
    localparam int STEP_W = 4;
    localparam int MASK   = (1 << WIDTH) - 1;

    logic clk = 1'b0;
    logic reset;

    mod_counter_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus ();

    mod_counter #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int count;
        int busy;
        int done;
        int tc;
        int match;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // Reference model: 0 idle, 1 run, 2 done
    int m_count = 0;
    int m_state = 0;
    int m_tc    = 0;
    int m_match = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int lim, stp, r, md;
        lim = int'(bus.limit);
        stp = int'(bus.step);
        md  = int'(bus.mode);
        m_tc = 0;
        if (reset) begin
            m_count = 0;
            m_state = 0;
            m_match = 0;
            return;
        end
        if (bus.stop) begin
            m_state = 0;
        end else if (bus.load_en) begin
            m_count = (int'(bus.load_val) < lim) ? int'(bus.load_val) : lim;
            if (bus.start) m_state = 1;
        end else if (bus.start) begin
            m_state = 1;
        end else if (m_state == 1 && bus.enable && stp != 0) begin
            if (bus.up_down) begin
                r = m_count + stp;
                if (r > lim) begin
                    m_tc = 1;
                    if (md == 1)      m_count = lim;
                    else if (md == 2) begin m_count = lim; m_state = 2; end
                    else              m_count = (r - (lim + 1)) & MASK;
                end else begin
                    m_count = r;
                    if (md == 2 && r == lim) begin m_tc = 1; m_state = 2; end
                end
            end else begin
                r = m_count - stp;
                if (r < 0) begin
                    m_tc = 1;
                    if (md == 1)      m_count = 0;
                    else if (md == 2) begin m_count = 0; m_state = 2; end
                    else              m_count = r + lim + 1;
                end else begin
                    m_count = r;
                    if (md == 2 && r == 0) begin m_tc = 1; m_state = 2; end
                end
            end
        end
`ifdef COUNTER_MATCH_EN
        m_match = (m_count == int'(bus.match_val)) ? 1 : 0;
`endif
    endtask

    // Inputs are stable here; predict the post-edge outputs, then cross the edge.
    task automatic tick();
        exp_t e;
        model_step();
        e.count = m_count;
        e.busy  = (m_state == 1) ? 1 : 0;
        e.done  = (m_state == 2) ? 1 : 0;
        e.tc    = m_tc;
        e.match = m_match;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("sb_count", int'(bus.count), e.count);
            chk("sb_busy",  int'(bus.busy),  e.busy);
            chk("sb_done",  int'(bus.done),  e.done);
            chk("sb_tc",    int'(bus.tc),    e.tc);
`ifdef COUNTER_MATCH_EN
            chk("sb_match", int'(bus.match), e.match);
`endif
        end
    end

    task automatic clear_inputs();
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.enable   = 1'b0;
        bus.up_down  = 1'b1;
        bus.mode     = 2'd0;
        bus.step     = '0;
        bus.limit    = '0;
        bus.load_en  = 1'b0;
        bus.load_val = '0;
`ifdef COUNTER_MATCH_EN
        bus.match_val = '0;
`endif
    endtask

    initial begin
        int exp_w[5];
        int lim, smax;
        exp_w[0] = 3; exp_w[1] = 6; exp_w[2] = 9; exp_w[3] = 2; exp_w[4] = 5;

        reset = 1'b1;
        clear_inputs();
        #3;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("reset_count", int'(bus.count), 0);
        chk("reset_busy",  int'(bus.busy),  0);

        // Wrap up: limit 9, step 3
        bus.limit = 8'd9; bus.step = 4'd3; bus.mode = 2'd0; bus.up_down = 1'b1;
        bus.enable = 1'b1; bus.start = 1'b1;
`ifdef COUNTER_MATCH_EN
        bus.match_val = 8'd6;
`endif
        tick();
        bus.start = 1'b0;
        chk("wrap_start_busy", int'(bus.busy), 1);
        chk("wrap_start_count", int'(bus.count), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("wrap_count", int'(bus.count), exp_w[i]);
            chk("wrap_tc", int'(bus.tc), (i == 3) ? 1 : 0);
`ifdef COUNTER_MATCH_EN
            chk("wrap_match", int'(bus.match), (exp_w[i] == 6) ? 1 : 0);
`endif
        end

        // Saturate down: limit 200, load 4, step 3
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
        bus.limit = 8'd200; bus.load_en = 1'b1; bus.load_val = 8'd4; bus.start = 1'b1;
        bus.mode = 2'd1; bus.up_down = 1'b0; bus.step = 4'd3; bus.enable = 1'b1;
        tick();
        bus.load_en = 1'b0; bus.start = 1'b0;
        chk("sat_load", int'(bus.count), 4);
        tick(); chk("sat_c1", int'(bus.count), 1); chk("sat_tc1", int'(bus.tc), 0);
        tick(); chk("sat_c2", int'(bus.count), 0); chk("sat_tc2", int'(bus.tc), 1);
        tick(); chk("sat_c3", int'(bus.count), 0); chk("sat_tc3", int'(bus.tc), 1);
        chk("sat_busy", int'(bus.busy), 1);

        // One-shot up: limit 10, step 5
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
        bus.limit = 8'd10; bus.load_en = 1'b1; bus.load_val = 8'd0; bus.start = 1'b1;
        bus.mode = 2'd2; bus.up_down = 1'b1; bus.step = 4'd5;
        tick();
        bus.load_en = 1'b0; bus.start = 1'b0;
        tick(); chk("os_c1", int'(bus.count), 5);
        tick(); chk("os_c2", int'(bus.count), 10);
        chk("os_done", int'(bus.done), 1); chk("os_tc", int'(bus.tc), 1); chk("os_busy", int'(bus.busy), 0);
        tick(); chk("os_hold", int'(bus.count), 10); chk("os_tc_drop", int'(bus.tc), 0);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        chk("os_restart_busy", int'(bus.busy), 1); chk("os_restart_done", int'(bus.done), 0);

        // Priority: load clamps and suppresses step; stop beats start
        bus.limit = 8'd100; bus.mode = 2'd0; bus.load_en = 1'b1; bus.load_val = 8'd250;
        tick();
        bus.load_en = 1'b0;
        chk("prio_clamp", int'(bus.count), 100);
        bus.stop = 1'b1; bus.start = 1'b1;
        tick();
        bus.stop = 1'b0; bus.start = 1'b0;
        chk("prio_stop", int'(bus.busy), 0);

        // Asynchronous reset mid-run at count 37
        bus.limit = 8'd200; bus.load_en = 1'b1; bus.load_val = 8'd37; bus.start = 1'b1;
        tick();
        bus.load_en = 1'b0; bus.start = 1'b0; bus.enable = 1'b0;
        tick();
        chk("pre_reset_count", int'(bus.count), 37);
        reset = 1'b1;
        #1;
        chk("async_count", int'(bus.count), 0);
        chk("async_busy",  int'(bus.busy),  0);
        chk("async_done",  int'(bus.done),  0);
        chk("async_tc",    int'(bus.tc),    0);
        tick();
        reset = 1'b0;

        // Random phase
        lim = 9;
        bus.limit = 8'(lim);
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                lim = $urandom_range(0, 255);
                bus.limit = 8'(lim);
            end
            if ($urandom_range(0, 29) == 0) bus.mode = 2'($urandom_range(0, 3));
            smax = (lim + 1 < 15) ? lim + 1 : 15;
            bus.step     = 4'($urandom_range(0, smax));
            bus.stop     = ($urandom_range(0, 39) == 0);
            bus.start    = ($urandom_range(0, 9) == 0);
            bus.load_en  = ($urandom_range(0, 19) == 0);
            bus.load_val = 8'($urandom_range(0, 255));
            bus.enable   = ($urandom_range(0, 3) != 0);
            bus.up_down  = 1'($urandom_range(0, 1));
`ifdef COUNTER_MATCH_EN
            bus.match_val = 8'($urandom_range(0, 15));
`endif
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        clear_inputs();
        tick();
        #10;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
